// File: rtl/ibex_wb_queue.sv
`default_nettype none
// ============================================================================
// Module   : ibex_wb_queue
// Purpose  : In-order multi-entry writeback queue between ID/EX and the RF.
//            Define IBEX_WB_INSTR_TRACE_EN to keep per-entry instruction words.
// Revision : 1.0
// ============================================================================
module ibex_wb_queue #(
   parameter int Depth = 2
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       en_wb_i,
   input  logic [1:0]                 instr_type_wb_i,
   input  logic [31:0]                pc_id_i,
   input  logic [31:0]                instr_rdata_id_i,
   input  logic                       instr_is_compressed_id_i,
   input  logic                       instr_perf_count_id_i,
   input  logic [4:0]                 rf_waddr_id_i,
   input  logic [31:0]                rf_wdata_id_i,
   input  logic                       rf_we_id_i,
   input  logic [4:0]                 rf_raddr_a_i,
   input  logic [4:0]                 rf_raddr_b_i,
   input  logic [31:0]                rf_wdata_lsu_i,
   input  logic                       rf_we_lsu_i,
   input  logic                       lsu_resp_valid_i,
   input  logic                       lsu_resp_err_i,
   output logic                       ready_wb_o,
   output logic [$clog2(Depth+1)-1:0] occupancy_o,
   output logic                       rf_write_wb_o,
   output logic                       hazard_a_o,
   output logic                       hazard_b_o,
   output logic                       outstanding_load_wb_o,
   output logic                       outstanding_store_wb_o,
   output logic [31:0]                pc_wb_o,
   output logic [31:0]                rf_wdata_fwd_wb_o,
   output logic [4:0]                 rf_waddr_wb_o,
   output logic [31:0]                rf_wdata_wb_o,
   output logic                       rf_we_wb_o,
   output logic                       instr_done_wb_o,
   output logic [31:0]                instr_done_rdata_wb_o,
   output logic                       perf_instr_ret_wb_o,
   output logic                       perf_instr_ret_compressed_wb_o
);

   localparam logic [1:0] WB_INSTR_LOAD  = 2'b00;
   localparam logic [1:0] WB_INSTR_STORE = 2'b01;
   localparam logic [1:0] WB_INSTR_OTHER = 2'b10;
   localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
   localparam int CntW = $clog2(Depth + 1);

   logic [PtrW-1:0]  head_q, head_d, tail_q, tail_d;
   logic [CntW-1:0]  count_q, count_d;
   logic [Depth-1:0] valid_q;
   logic [Depth-1:0] rf_we_q;
   logic [Depth-1:0] compressed_q;
   logic [Depth-1:0] perf_count_q;
   logic [1:0]       type_q     [Depth];
   logic [31:0]      pc_q       [Depth];
   logic [4:0]       rf_waddr_q [Depth];
   logic [31:0]      rf_wdata_q [Depth];

   logic head_valid, head_done, push, pop, id_we, lsu_we;

   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
      return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
   endfunction

   assign head_valid = valid_q[head_q];
   assign head_done  = head_valid &
                       ((type_q[head_q] == WB_INSTR_OTHER) | lsu_resp_valid_i);
   assign pop        = head_done;
   assign ready_wb_o = (count_q < CntW'(Depth)) | head_done;
   assign push       = en_wb_i & ready_wb_o;

   assign head_d  = pop  ? ptr_inc(head_q) : head_q;
   assign tail_d  = push ? ptr_inc(tail_q) : tail_q;
   assign count_d = count_q + CntW'(push) - CntW'(pop);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         valid_q <= '0;
         rf_we_q <= '0;
         compressed_q <= '0;
         perf_count_q <= '0;
         for (int i = 0; i < Depth; i++) begin
            type_q[i]     <= '0;
            pc_q[i]       <= '0;
            rf_waddr_q[i] <= '0;
            rf_wdata_q[i] <= '0;
         end
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         // Clear before set: at full, a simultaneous push reuses the popped slot.
         if (pop) valid_q[head_q] <= 1'b0;
         if (push) begin
            valid_q[tail_q]      <= 1'b1;
            rf_we_q[tail_q]      <= rf_we_id_i;
            compressed_q[tail_q] <= instr_is_compressed_id_i;
            perf_count_q[tail_q] <= instr_perf_count_id_i;
            type_q[tail_q]       <= instr_type_wb_i;
            pc_q[tail_q]         <= pc_id_i;
            rf_waddr_q[tail_q]   <= rf_waddr_id_i;
            rf_wdata_q[tail_q]   <= rf_wdata_id_i;
         end
      end
   end

   always_comb begin
      rf_write_wb_o          = 1'b0;
      hazard_a_o             = 1'b0;
      hazard_b_o             = 1'b0;
      outstanding_load_wb_o  = 1'b0;
      outstanding_store_wb_o = 1'b0;
      for (int i = 0; i < Depth; i++) begin
         if (valid_q[i]) begin
            if (type_q[i] == WB_INSTR_LOAD)  outstanding_load_wb_o  = 1'b1;
            if (type_q[i] == WB_INSTR_STORE) outstanding_store_wb_o = 1'b1;
            if (rf_we_q[i] | (type_q[i] == WB_INSTR_LOAD)) begin
               rf_write_wb_o = 1'b1;
               // A head OTHER result is already on the forwarding path; a head LOAD is not.
               if ((PtrW'(i) != head_q) | (type_q[i] == WB_INSTR_LOAD)) begin
                  if ((rf_raddr_a_i != 5'd0) & (rf_waddr_q[i] == rf_raddr_a_i)) hazard_a_o = 1'b1;
                  if ((rf_raddr_b_i != 5'd0) & (rf_waddr_q[i] == rf_raddr_b_i)) hazard_b_o = 1'b1;
               end
            end
         end
      end
   end

   assign id_we  = head_valid & rf_we_q[head_q];
   assign lsu_we = head_valid & rf_we_lsu_i;

   assign occupancy_o       = count_q;
   assign pc_wb_o           = pc_q[head_q];
   assign rf_wdata_fwd_wb_o = rf_wdata_q[head_q];
   assign rf_waddr_wb_o     = rf_waddr_q[head_q];
   assign rf_wdata_wb_o     = id_we ? rf_wdata_q[head_q] : rf_wdata_lsu_i;
   assign rf_we_wb_o        = id_we | lsu_we;
   assign instr_done_wb_o   = head_done;

   assign perf_instr_ret_wb_o = head_done & perf_count_q[head_q] &
                                ~(lsu_resp_valid_i & lsu_resp_err_i);
   assign perf_instr_ret_compressed_wb_o = perf_instr_ret_wb_o & compressed_q[head_q];

`ifdef IBEX_WB_INSTR_TRACE_EN
   logic [31:0] instr_q [Depth];

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < Depth; i++) instr_q[i] <= '0;
      end else if (push) begin
         instr_q[tail_q] <= instr_rdata_id_i;
      end
   end

   assign instr_done_rdata_wb_o = instr_q[head_q];
`else
   logic unused_instr_rdata;
   assign unused_instr_rdata    = ^instr_rdata_id_i;
   assign instr_done_rdata_wb_o = '0;
`endif

   a_single_rf_source: assert property (@(posedge clk_i) disable iff (rst_i)
      !(id_we && rf_we_lsu_i));
   a_lsu_resp_needs_lsu_head: assert property (@(posedge clk_i) disable iff (rst_i)
      lsu_resp_valid_i |-> (head_valid && (type_q[head_q] != WB_INSTR_OTHER)));

endmodule
`default_nettype wire
